// File: rtl/vga_text_pkg.sv
// Shared types and constants for the text-mode character buffer.
package vga_text_pkg;

  localparam int TEXT_COLS   = 70;
  localparam int TEXT_ROWS   = 30;
  localparam int CELL_ADDR_W = 12;

  typedef struct packed {
    logic [11:0] front;
    logic [11:0] back;
    logic [7:0]  ascii;
  } cell_t;

  localparam logic [31:0] BLANK_CELL = 32'hFFF0_0020;

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

endpackage

// File: rtl/vga_char_store_char_ram.sv
// 1W1R single-clock cell RAM, read-first, 1-cycle registered output.
// The output register clears synchronously on reset; the array itself is never reset.
module char_ram
  import vga_text_pkg::*;
#(
  parameter int ADDR_W = CELL_ADDR_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  cell_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output cell_t             o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  cell_t r_mem [0:DEPTH-1];
  cell_t r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-address read sees the pre-write contents.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_char_store.sv
// Scrolled text-cell buffer with power-on clear sweep; reads have 1-cycle latency.
// Optional blinking cursor flag enabled by `define VGA_CHAR_CURSOR_EN.
module vga_char_store
  import vga_text_pkg::*;
#(
  parameter logic [31:0] CLEAR_WORD = BLANK_CELL,
  parameter int          H_BITS     = 7,
  parameter int          V_BITS     = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [H_BITS-1:0] i_wr_h,
  input  logic [V_BITS-1:0] i_wr_v,
  input  logic [31:0]       i_wr_data,
  input  logic [H_BITS-1:0] i_rd_h,
  input  logic [V_BITS-1:0] i_rd_v,
  input  logic [V_BITS-1:0] i_line_offset,
  input  logic [H_BITS-1:0] i_cursor_h,
  input  logic [V_BITS-1:0] i_cursor_v,
  input  logic              i_blink,
  output logic [31:0]       o_rd_data,
  output logic [11:0]       o_rd_front,
  output logic [11:0]       o_rd_back,
  output logic [7:0]        o_rd_char,
  output logic              o_rd_cursor,
  output logic              o_rd_valid,
  output logic              o_busy
);

  localparam int                ADDR_W    = H_BITS + V_BITS;
  localparam logic [ADDR_W-1:0] LAST_CELL = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_sweep_ptr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_SWEEP;
      r_sweep_ptr <= '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          r_sweep_ptr <= r_sweep_ptr + ADDR_W'(1);
          if (r_sweep_ptr == LAST_CELL) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic w_sweeping;
  logic w_busy;
  assign w_sweeping = (r_state == ST_SWEEP);
  assign w_busy     = i_reset | w_sweeping;

  // The sweep owns the write port; CPU writes during it are discarded.
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  cell_t             w_wdata;
  assign w_we    = w_sweeping ? ~i_reset : (i_wr_en & ~i_reset);
  assign w_waddr = w_sweeping ? r_sweep_ptr : {i_wr_h, i_wr_v};
  assign w_wdata = w_sweeping ? cell_t'(CLEAR_WORD) : cell_t'(i_wr_data);

  logic [V_BITS-1:0] w_phys_row;
  assign w_phys_row = i_rd_v + i_line_offset;

  cell_t w_rd_cell;

  char_ram #(
    .ADDR_W (ADDR_W)
  ) u_char_ram (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr ({i_rd_h, w_phys_row}),
    .o_rdata (w_rd_cell)
  );

  assign o_rd_data  = w_rd_cell;
  assign o_rd_front = w_rd_cell.front;
  assign o_rd_back  = w_rd_cell.back;
  assign o_rd_char  = w_rd_cell.ascii;
  assign o_busy     = w_busy;
  assign o_rd_valid = ~w_busy;

`ifdef VGA_CHAR_CURSOR_EN
  // Cursor position is in screen coordinates, so compare against the unscrolled row.
  logic r_cursor;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cursor <= 1'b0;
    end else begin
      r_cursor <= (i_rd_h == i_cursor_h) & (i_rd_v == i_cursor_v) & i_blink;
    end
  end
  assign o_rd_cursor = r_cursor;
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{i_cursor_h, i_cursor_v, i_blink};
  assign o_rd_cursor     = 1'b0;
`endif

endmodule

// File: tb/tb_vga_char_store.sv
// Randomised bench for vga_char_store with a cell-array reference model and literal anchors.
module tb_vga_char_store;

`ifdef VGA_CHAR_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif
  localparam logic [31:0] CLR = 32'hFFF0_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_h = '0;
  logic [4:0]  wr_v = '0;
  logic [31:0] wr_data = '0;
  logic [6:0]  rd_h = '0;
  logic [4:0]  rd_v = '0;
  logic [4:0]  line_offset = '0;
  logic [6:0]  cursor_h = '0;
  logic [4:0]  cursor_v = '0;
  logic        blink = 1'b0;
  logic [31:0] rd_data;
  logic [11:0] rd_front, rd_back;
  logic [7:0]  rd_char;
  logic        rd_cursor, rd_valid, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_char_store dut (
    .i_clock(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_h(wr_h), .i_wr_v(wr_v),
    .i_wr_data(wr_data), .i_rd_h(rd_h), .i_rd_v(rd_v), .i_line_offset(line_offset),
    .i_cursor_h(cursor_h), .i_cursor_v(cursor_v), .i_blink(blink),
    .o_rd_data(rd_data), .o_rd_front(rd_front), .o_rd_back(rd_back), .o_rd_char(rd_char),
    .o_rd_cursor(rd_cursor), .o_rd_valid(rd_valid), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain array of cells plus a count of cleared cells since reset.
  logic [31:0] m_mem [4096];
  bit          m_known [4096];
  int          m_cleared = 0;
  logic [31:0] m_rd = '0;
  bit          m_rd_known = 1'b0;
  bit          m_cur = 1'b0;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    int ra;
    if (reset) begin
      m_rd = '0; m_rd_known = 1'b1; m_cur = 1'b0; m_cleared = 0; m_started = 1'b1;
    end else begin
      ra = int'(rd_h) * 32 + ((int'(rd_v) + int'(line_offset)) % 32);
      m_rd = m_mem[ra];
      m_rd_known = m_known[ra];
      m_cur = CUR_EN && (rd_h == cursor_h) && (rd_v == cursor_v) && blink;
      if (m_cleared < 4096) begin
        m_mem[m_cleared] = CLR;
        m_known[m_cleared] = 1'b1;
        m_cleared++;
      end else if (wr_en) begin
        m_mem[int'(wr_h) * 32 + int'(wr_v)] = wr_data;
        m_known[int'(wr_h) * 32 + int'(wr_v)] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_busy;
    if (m_started) begin
      exp_busy = reset || (m_cleared < 4096);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("rd_valid", 32'(rd_valid), 32'(!exp_busy));
      chk("rd_cursor", 32'(rd_cursor), 32'(m_cur));
      if (m_rd_known) begin
        chk("rd_data", rd_data, m_rd);
        chk("rd_front", 32'(rd_front), 32'(m_rd[31:20]));
        chk("rd_back", 32'(rd_back), 32'(m_rd[19:8]));
        chk("rd_char", 32'(rd_char), 32'(m_rd[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
      if (n == 1) wr_en = 1'b0;
    end
    chk(name, 32'(n), 32'd4096);
  endtask

  task automatic set_rd(input logic [6:0] h, input logic [4:0] v, input logic [4:0] off);
    rd_h = h; rd_v = v; line_offset = off;
  endtask

  initial begin
    // Reset and first sweep; a write attempted during the sweep must be lost.
    repeat (3) tick();
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    wr_en = 1'b1; wr_h = 7'd1; wr_v = 5'd1; wr_data = 32'hDEADBEEF;
    count_busy("sweep_len");
    chk("valid_after_sweep", 32'(rd_valid), 32'd1);

    set_rd(7'd100, 5'd31, 5'd0); tick();
    chk("cleared_cell", rd_data, 32'hFFF00020);
    set_rd(7'd1, 5'd1, 5'd0); tick();
    chk("dropped_write", rd_data, 32'hFFF00020);

    wr_en = 1'b1; wr_h = 7'd5; wr_v = 5'd3; wr_data = 32'h0F000041; tick();
    wr_en = 1'b0; set_rd(7'd5, 5'd3, 5'd0); tick();
    chk("write_read", rd_data, 32'h0F000041);
    chk("write_read_char", 32'(rd_char), 32'h41);

    wr_en = 1'b1; wr_h = 7'd0; wr_v = 5'd1; wr_data = 32'h00000058; tick();
    wr_en = 1'b0; set_rd(7'd0, 5'd31, 5'd2); tick();
    chk("scroll_wrap_char", 32'(rd_char), 32'h58);

    wr_en = 1'b1; wr_h = 7'd2; wr_v = 5'd2; wr_data = 32'h12345678;
    set_rd(7'd2, 5'd2, 5'd0); tick();
    chk("read_first_old", rd_data, 32'hFFF00020);
    wr_en = 1'b0; tick();
    chk("read_first_new", rd_data, 32'h12345678);

    cursor_h = 7'd4; cursor_v = 5'd2; blink = 1'b1; set_rd(7'd4, 5'd2, 5'd7); tick();
    chk("cursor_on", 32'(rd_cursor), 32'(CUR_EN));
    blink = 1'b0; tick();
    chk("cursor_blink_off", 32'(rd_cursor), 32'd0);
    blink = 1'b1; cursor_v = 5'd3; tick();
    chk("cursor_other_row", 32'(rd_cursor), 32'd0);

    // Random traffic with small cursor/address ranges so hits actually occur.
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_h = 7'($urandom_range(0, 7)); wr_v = 5'($urandom);
      wr_data = $urandom;
      rd_h = 7'($urandom_range(0, 7)); rd_v = 5'($urandom);
      line_offset = 5'($urandom);
      cursor_h = 7'($urandom_range(0, 3)); cursor_v = 5'($urandom_range(0, 3));
      if (($urandom & 1) == 0) begin rd_h = cursor_h; rd_v = cursor_v; end
      blink = 1'($urandom);
      tick();
    end
    wr_en = 1'b0;

    // Reset part-way through a sweep restarts it from cell 0.
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (100) tick();
    chk("mid_sweep_busy", 32'(busy), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    count_busy("restart_sweep_len");
    set_rd(7'd5, 5'd3, 5'd0); tick();
    chk("recleared_cell", rd_data, 32'hFFF00020);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
